// File: rtl/ws2811_pkg.sv
// Shared WS2811/WS2812 constants and types for the line transmitter and receiver.
// Default timings assume a 50 MHz system clock.
package ws2811_pkg;

  localparam int PIXEL_WIDTH       = 24;
  localparam int DEFAULT_CLK_HZ    = 50_000_000;
  localparam int T0H_CYCLES        = 12;
  localparam int T1H_CYCLES        = 30;
  localparam int BIT_PERIOD_CYCLES = 62;
  localparam int RESET_CYCLES      = 2500;

  typedef enum logic [1:0] {
    WAIT_RESET,
    IDLE_LOW,
    BIT_HIGH,
    BIT_LOW
  } rx_state_t;

  // The 0/1 decision point sits just above the midpoint of the two nominal high times.
  function automatic int decodeThreshold(input int t0h, input int t1h);
    return (t0h + t1h) / 2 + 1;
  endfunction

endpackage

// File: rtl/ws2811_line_sync.sv
// Two-flop synchronizer for the serial line plus a registered copy for rise/fall strobes.
module ws2811_line_sync (
  input  logic clkIN,
  input  logic nResetIN,
  input  logic dataIN,
  output logic line,
  output logic rise,
  output logic fall
);

  logic syncA;
  logic syncB;
  logic lineDly;

  always_ff @(posedge clkIN or negedge nResetIN) begin
    if (!nResetIN) begin
      syncA   <= 1'b0;
      syncB   <= 1'b0;
      lineDly <= 1'b0;
    end else begin
      syncA   <= dataIN;
      syncB   <= syncA;
      lineDly <= syncB;
    end
  end

  assign line = syncB;
  assign rise = syncB & ~lineDly;
  assign fall = ~syncB & lineDly;

endmodule

// File: rtl/ws2811_line_receiver.sv
// WS2811/WS2812 NRZ line decoder: times high pulses in clock cycles, assembles MSB-first
// 24-bit pixels and reports pixel, frame-end and protocol-error events as 1-cycle pulses.
module ws2811_line_receiver
  import ws2811_pkg::*;
#(
  parameter int CLK_HZ                = DEFAULT_CLK_HZ,
  parameter int MIN_HIGH_CYCLES       = 4,
  parameter int HIGH_THRESHOLD_CYCLES = decodeThreshold(T0H_CYCLES, T1H_CYCLES),
  parameter int MAX_HIGH_CYCLES       = 50,
  parameter int RESET_LOW_CYCLES      = RESET_CYCLES,
  parameter int PIXELS_MAX            = 256,
  localparam int IndexW               = $clog2(PIXELS_MAX)
) (
  input  logic                   clkIN,
  input  logic                   nResetIN,
  input  logic                   dataIN,
  output logic [PIXEL_WIDTH-1:0] pixelOUT,
  output logic                   pixelValidOUT,
  output logic [IndexW-1:0]      pixelIndexOUT,
  output logic                   frameEndOUT,
  output logic                   errorOUT
);

  localparam int CountW = $clog2(RESET_LOW_CYCLES + 1);
  localparam int BitW   = $clog2(PIXEL_WIDTH);

  localparam logic [CountW-1:0] CountMinHigh   = CountW'(MIN_HIGH_CYCLES);
  localparam logic [CountW-1:0] CountThreshold = CountW'(HIGH_THRESHOLD_CYCLES);
  localparam logic [CountW-1:0] CountMaxHigh   = CountW'(MAX_HIGH_CYCLES);
  localparam logic [CountW-1:0] CountResetLow  = CountW'(RESET_LOW_CYCLES);
  localparam logic [BitW-1:0]   LastBitIdx     = BitW'(PIXEL_WIDTH - 1);
  localparam logic [IndexW-1:0] LastIndex      = IndexW'(PIXELS_MAX - 1);

  if (CLK_HZ <= 0 || MIN_HIGH_CYCLES >= HIGH_THRESHOLD_CYCLES ||
      HIGH_THRESHOLD_CYCLES >= MAX_HIGH_CYCLES || MAX_HIGH_CYCLES >= RESET_LOW_CYCLES) begin : gBadParams
    $error("ws2811_line_receiver: inconsistent timing parameters");
  end

  logic syncLine;
  logic lineRise;
  logic lineFall;

  ws2811_line_sync uLineSync (
    .clkIN    (clkIN),
    .nResetIN (nResetIN),
    .dataIN   (dataIN),
    .line     (syncLine),
    .rise     (lineRise),
    .fall     (lineFall)
  );

  rx_state_t               state;
  rx_state_t               stateNext;
  logic [CountW-1:0]       count;
  logic [PIXEL_WIDTH-1:0]  shiftReg;
  logic [PIXEL_WIDTH-1:0]  shiftIn;
  logic [BitW-1:0]         bitCount;
  logic [IndexW-1:0]       pixelIndex;

  // The edge cycle is already the first cycle at the new level, so the count restarts at 1:
  // in the first cycle of the opposite level it equals the length of the previous run.
  always_ff @(posedge clkIN or negedge nResetIN) begin
    if (!nResetIN) begin
      count <= '0;
    end else if (lineRise || lineFall) begin
      count <= CountW'(1);
    end else if (count != CountResetLow) begin
      count <= count + 1'b1;
    end
  end

  logic highTimeout;
  logic highFall;
  logic shortPulse;
  logic bitAccept;
  logic lowGap;
  logic resetDone;
  logic bitValue;
  logic lastBit;

  assign highTimeout = (state == BIT_HIGH) && (count >= CountMaxHigh);
  assign highFall    = (state == BIT_HIGH) && lineFall && !highTimeout;
  assign shortPulse  = highFall && (count < CountMinHigh);
  assign bitAccept   = highFall && !shortPulse;
  assign lowGap      = (state == BIT_LOW) && !lineRise && (count == CountResetLow);
  // A fall cycle still carries the saturated high count, so it must not end the wait.
  assign resetDone   = (state == WAIT_RESET) && !syncLine && !lineFall && (count == CountResetLow);
  assign bitValue    = (count >= CountThreshold);
  assign lastBit     = (bitCount == LastBitIdx);
  assign shiftIn     = {shiftReg[PIXEL_WIDTH-2:0], bitValue};

  always_ff @(posedge clkIN or negedge nResetIN) begin
    if (!nResetIN) begin
      state <= WAIT_RESET;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      WAIT_RESET: if (resetDone) stateNext = IDLE_LOW;
      IDLE_LOW:   if (lineRise) stateNext = BIT_HIGH;
      BIT_HIGH: begin
        if (highTimeout || shortPulse) stateNext = WAIT_RESET;
        else if (bitAccept)            stateNext = BIT_LOW;
      end
      BIT_LOW: begin
        if (lineRise)    stateNext = BIT_HIGH;
        else if (lowGap) stateNext = IDLE_LOW;
      end
      default: stateNext = WAIT_RESET;
    endcase
  end

  logic errorNext;
  logic frameEndNext;
  logic pixelValidNext;
  logic clearFrame;

  always_comb begin
    errorNext      = highTimeout || shortPulse || (lowGap && (bitCount != '0));
    frameEndNext   = lowGap;
    pixelValidNext = bitAccept && lastBit;
    clearFrame     = errorNext || frameEndNext;
  end

  always_ff @(posedge clkIN or negedge nResetIN) begin
    if (!nResetIN) begin
      pixelOUT      <= '0;
      pixelValidOUT <= 1'b0;
      pixelIndexOUT <= '0;
      frameEndOUT   <= 1'b0;
      errorOUT      <= 1'b0;
      shiftReg      <= '0;
      bitCount      <= '0;
      pixelIndex    <= '0;
    end else begin
      pixelValidOUT <= pixelValidNext;
      frameEndOUT   <= frameEndNext;
      errorOUT      <= errorNext;
      if (clearFrame) begin
        bitCount   <= '0;
        pixelIndex <= '0;
      end else if (bitAccept) begin
        shiftReg <= shiftIn;
        if (lastBit) begin
          pixelOUT      <= shiftIn;
          pixelIndexOUT <= pixelIndex;
          bitCount      <= '0;
          pixelIndex    <= (pixelIndex == LastIndex) ? '0 : pixelIndex + 1'b1;
        end else begin
          bitCount <= bitCount + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ws2811_line_receiver.sv
// Directed bench for ws2811_line_receiver: drives NRZ waveforms cycle by cycle and
// compares logged output pulses against hand-computed pixels, indices and latencies.
module tb_ws2811_line_receiver;
  import ws2811_pkg::*;

  logic        clkIN = 1'b0;
  logic        nResetIN = 1'b0;
  logic        dataIN = 1'b0;
  logic [23:0] pixelOUT;
  logic        pixelValidOUT;
  logic [7:0]  pixelIndexOUT;
  logic        frameEndOUT;
  logic        errorOUT;

  ws2811_line_receiver dut (
    .clkIN         (clkIN),
    .nResetIN      (nResetIN),
    .dataIN        (dataIN),
    .pixelOUT      (pixelOUT),
    .pixelValidOUT (pixelValidOUT),
    .pixelIndexOUT (pixelIndexOUT),
    .frameEndOUT   (frameEndOUT),
    .errorOUT      (errorOUT)
  );

  always #5 clkIN = ~clkIN;

  int cyc = 0;
  always @(posedge clkIN) cyc <= cyc + 1;

  int checkCount = 0;
  int failCount  = 0;

  task automatic checkEq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Output event log, sampled on the falling edge
  logic [23:0] pixVals[$];
  int          pixIdx[$];
  int          pixCyc[$];
  int          frameCount = 0;
  int          errCount = 0;
  int          bothCount = 0;
  int          errCyc = 0;
  int          widePulse = 0;
  logic        prevValid = 1'b0;
  logic        prevFrame = 1'b0;
  logic        prevErr = 1'b0;

  always @(negedge clkIN) begin
    if (pixelValidOUT) begin
      pixVals.push_back(pixelOUT);
      pixIdx.push_back(int'(pixelIndexOUT));
      pixCyc.push_back(cyc);
      $display("pixel idx=%0d value=%06h cycle=%0d", pixelIndexOUT, pixelOUT, cyc);
    end
    if (frameEndOUT) begin
      frameCount++;
      $display("frame_end cycle=%0d", cyc);
    end
    if (errorOUT) begin
      errCount++;
      errCyc = cyc;
      $display("protocol_error cycle=%0d", cyc);
    end
    if (errorOUT && frameEndOUT) bothCount++;
    if ((prevValid && pixelValidOUT) || (prevFrame && frameEndOUT) || (prevErr && errorOUT))
      widePulse++;
    prevValid = pixelValidOUT;
    prevFrame = frameEndOUT;
    prevErr   = errorOUT;
  end

  task automatic clearLog();
    pixVals.delete();
    pixIdx.delete();
    pixCyc.delete();
    frameCount = 0;
    errCount   = 0;
    bothCount  = 0;
  endtask

  int lastFall = 0;

  // Hold the line for exactly n sampling edges; returns 1 time unit after the last one.
  task automatic hold(input logic lvl, input int n);
    dataIN = lvl;
    repeat (n) @(posedge clkIN);
    #1;
  endtask

  task automatic sendBitW(input int hi, input int lo);
    hold(1'b1, hi);
    lastFall = cyc;
    hold(1'b0, lo);
  endtask

  task automatic sendBit(input logic b);
    if (b) sendBitW(30, 32);
    else   sendBitW(12, 50);
  endtask

  task automatic sendPixel(input logic [23:0] v);
    for (int i = 23; i >= 0; i--) sendBit(v[i]);
  endtask

  task automatic sendFastZeroPixel();
    for (int i = 0; i < 24; i++) sendBitW(4, 1);
  endtask

  initial begin
    int          startHigh;
    int          seqBad;
    logic [19:0] tail;
    logic [23:0] expPix[3];

    @(posedge clkIN);
    #1;
    repeat (3) @(posedge clkIN);
    #1;
    checkEq("reset_pixel", 32'(pixelOUT), 32'h0);
    checkEq("reset_valid", 32'(pixelValidOUT), 32'h0);
    checkEq("reset_index", 32'(pixelIndexOUT), 32'h0);
    checkEq("reset_frame_end", 32'(frameEndOUT), 32'h0);
    checkEq("reset_error", 32'(errorOUT), 32'h0);
    nResetIN = 1'b1;

    // Single pixel frame
    clearLog();
    hold(1'b0, 2600);
    sendPixel(24'hA53CF0);
    hold(1'b0, 2600);
    checkEq("p1_count", 32'(pixVals.size()), 32'd1);
    if (pixVals.size() >= 1) begin
      checkEq("p1_value", 32'(pixVals[0]), 32'hA53CF0);
      checkEq("p1_index", 32'(pixIdx[0]), 32'd0);
      checkEq("p1_latency", 32'(pixCyc[0] - lastFall), 32'd3);
    end
    checkEq("p1_frame_end", 32'(frameCount), 32'd1);
    checkEq("p1_error", 32'(errCount), 32'd0);
    checkEq("p1_hold", 32'(pixelOUT), 32'hA53CF0);

    // Three pixels in one frame, then a fresh frame restarting at index 0
    clearLog();
    expPix[0] = 24'h000000;
    expPix[1] = 24'hFFFFFF;
    expPix[2] = 24'h123456;
    for (int p = 0; p < 3; p++) sendPixel(expPix[p]);
    hold(1'b0, 2600);
    checkEq("p3_count", 32'(pixVals.size()), 32'd3);
    for (int p = 0; p < 3 && p < pixVals.size(); p++) begin
      checkEq($sformatf("p3_value%0d", p), 32'(pixVals[p]), 32'(expPix[p]));
      checkEq($sformatf("p3_index%0d", p), 32'(pixIdx[p]), 32'(p));
    end
    checkEq("p3_frame_end", 32'(frameCount), 32'd1);
    checkEq("p3_error", 32'(errCount), 32'd0);
    clearLog();
    sendPixel(24'hABCDEF);
    hold(1'b0, 2600);
    checkEq("f2_count", 32'(pixVals.size()), 32'd1);
    if (pixVals.size() >= 1) begin
      checkEq("f2_value", 32'(pixVals[0]), 32'hABCDEF);
      checkEq("f2_index", 32'(pixIdx[0]), 32'd0);
    end

    // 2-cycle glitch mid-pixel: error, then bits ignored until a full reset gap
    clearLog();
    for (int i = 0; i < 10; i++) sendBit(i[0]);
    sendBitW(2, 50);
    for (int i = 0; i < 14; i++) sendBit(1'b1);
    checkEq("glitch_error", 32'(errCount), 32'd1);
    checkEq("glitch_no_pixel", 32'(pixVals.size()), 32'd0);
    hold(1'b0, 2600);
    checkEq("glitch_no_frame_end", 32'(frameCount), 32'd0);
    sendPixel(24'h5A5A5A);
    hold(1'b0, 2600);
    checkEq("glitch_recover_count", 32'(pixVals.size()), 32'd1);
    if (pixVals.size() >= 1) begin
      checkEq("glitch_recover_value", 32'(pixVals[0]), 32'h5A5A5A);
      checkEq("glitch_recover_index", 32'(pixIdx[0]), 32'd0);
    end
    checkEq("glitch_recover_frame_end", 32'(frameCount), 32'd1);
    checkEq("glitch_error_total", 32'(errCount), 32'd1);

    // Stuck-high line: error once the high count reaches 50
    clearLog();
    startHigh = cyc;
    hold(1'b1, 60);
    hold(1'b0, 2600);
    checkEq("stuck_error", 32'(errCount), 32'd1);
    checkEq("stuck_error_cycle", 32'(errCyc - startHigh), 32'd53);
    checkEq("stuck_no_frame_end", 32'(frameCount), 32'd0);
    checkEq("stuck_no_pixel", 32'(pixVals.size()), 32'd0);

    // Width boundaries: 22->1, 21->0, 49->1, 4->0, then nominal bits
    clearLog();
    sendBitW(22, 40);
    sendBitW(21, 41);
    sendBitW(49, 13);
    sendBitW(4, 58);
    tail = 20'h0F0F0;
    for (int i = 19; i >= 0; i--) sendBit(tail[i]);
    hold(1'b0, 2600);
    checkEq("width_count", 32'(pixVals.size()), 32'd1);
    if (pixVals.size() >= 1) checkEq("width_value", 32'(pixVals[0]), 32'hA0F0F0);
    checkEq("width_error", 32'(errCount), 32'd0);

    // Illegal widths 3 and 50 each raise a single error
    clearLog();
    sendBitW(3, 50);
    hold(1'b0, 2600);
    checkEq("short3_error", 32'(errCount), 32'd1);
    clearLog();
    sendBitW(50, 50);
    hold(1'b0, 2600);
    checkEq("long50_error", 32'(errCount), 32'd1);
    checkEq("long50_no_pixel", 32'(pixVals.size()), 32'd0);

    // Partial pixel at the reset gap: error and frame end together
    clearLog();
    for (int i = 0; i < 10; i++) sendBit(1'b1);
    hold(1'b0, 2600);
    checkEq("partial_both", 32'(bothCount), 32'd1);
    checkEq("partial_error", 32'(errCount), 32'd1);
    checkEq("partial_frame_end", 32'(frameCount), 32'd1);
    checkEq("partial_no_pixel", 32'(pixVals.size()), 32'd0);

    // 257 pixels in one frame: index wraps from 255 to 0
    clearLog();
    for (int p = 0; p < 256; p++) sendFastZeroPixel();
    sendPixel(24'h000001);
    hold(1'b0, 2600);
    checkEq("wrap_count", 32'(pixVals.size()), 32'd257);
    if (pixVals.size() >= 257) begin
      seqBad = 0;
      for (int k = 0; k < 257; k++) if (pixIdx[k] != (k % 256)) seqBad++;
      checkEq("wrap_sequence", 32'(seqBad), 32'd0);
      checkEq("wrap_index255", 32'(pixIdx[255]), 32'd255);
      checkEq("wrap_index256", 32'(pixIdx[256]), 32'd0);
      checkEq("wrap_value256", 32'(pixVals[256]), 32'h000001);
    end
    checkEq("wrap_error", 32'(errCount), 32'd0);

    // Reset mid-frame after bit 12
    clearLog();
    sendPixel(24'h13579B);
    sendPixel(24'h2468AC);
    for (int i = 0; i < 12; i++) sendBit(1'b1);
    checkEq("prereset_index", 32'(pixelIndexOUT), 32'd1);
    nResetIN = 1'b0;
    #1;
    checkEq("midreset_pixel", 32'(pixelOUT), 32'h0);
    checkEq("midreset_index", 32'(pixelIndexOUT), 32'h0);
    repeat (3) @(posedge clkIN);
    #1;
    nResetIN = 1'b1;
    clearLog();
    for (int i = 0; i < 12; i++) sendBit(1'b1);
    sendPixel(24'h111111);
    checkEq("postreset_ignored", 32'(pixVals.size()), 32'd0);
    hold(1'b0, 2600);
    checkEq("postreset_no_frame_end", 32'(frameCount), 32'd0);
    sendPixel(24'hC0FFEE);
    hold(1'b0, 2600);
    checkEq("postreset_count", 32'(pixVals.size()), 32'd1);
    if (pixVals.size() >= 1) begin
      checkEq("postreset_value", 32'(pixVals[0]), 32'hC0FFEE);
      checkEq("postreset_index", 32'(pixIdx[0]), 32'd0);
    end
    checkEq("postreset_error", 32'(errCount), 32'd0);

    checkEq("pulse_width", 32'(widePulse), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
